// File: rtl/airlock_sequencer_if.sv
// Request/grant, actuator and chamber-status bundle of the airlock sequencer.
// master = PIO/bench side driving requests; slave = the sequencer itself.
interface airlock_sequencer_if;
    logic       arrive_req;
    logic       depart_req;
    logic       pause;
    logic       arrive_grant;
    logic       depart_grant;
    logic       busy;
    logic       done;
    logic       evacuate;
    logic       pressurize;
    logic       outer_door;
    logic       inner_door;
    logic       pressurized;
    logic       evacuated;
    logic [2:0] dbg_state;

    modport master (
        output arrive_req, depart_req, pause,
        input  arrive_grant, depart_grant, busy, done, evacuate, pressurize,
               outer_door, inner_door, pressurized, evacuated, dbg_state
    );

    modport slave (
        input  arrive_req, depart_req, pause,
        output arrive_grant, depart_grant, busy, done, evacuate, pressurize,
               outer_door, inner_door, pressurized, evacuated, dbg_state
    );
endinterface

// File: rtl/airlock_sequencer.sv
// Airlock transit sequencer: round-robin arrive/depart arbitration and timed
// evacuate/pressurize/door phases with one actuator active at a time.
//
// state | meaning
// IDLE  | chamber closed, waiting for a request
// EVAC  | pump chamber down to vacuum
// PRESS | fill chamber to station pressure
// OUTER | outer door open (chamber at vacuum)
// INNER | inner door open (chamber at station pressure)
// DONE  | one-cycle completion, then back to IDLE
module airlock_sequencer #(
    parameter int EVAC_CYCLES  = 8,
    parameter int PRESS_CYCLES = 8,
    parameter int DOOR_CYCLES  = 4,
    parameter int CNT_W        = 8
) (
    input logic               clk,
    input logic               reset,
    airlock_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EVAC  = 3'd1,
        S_PRESS = 3'd2,
        S_OUTER = 3'd3,
        S_INNER = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] EVAC_LD  = CNT_W'(EVAC_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRESS_LD = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LD  = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, next_d;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q, last_dir_q, start_dir_d, advance_d, cnt_zero_d;
    logic             evac_q, press_q, outer_q, inner_q;
    logic             pressd_q, evacd_q, agrant_q, dgrant_q, done_q, busy_q;

    always_comb begin
        start_dir_d = 1'b0;
        if (bus.arrive_req && bus.depart_req) start_dir_d = ~last_dir_q;
        else if (bus.depart_req)              start_dir_d = 1'b1;
        cnt_zero_d = (cnt_q == '0);
        next_d     = S_IDLE;
        advance_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Skip the pump phase when the chamber already matches the door side.
                if (start_dir_d) next_d = pressd_q ? S_INNER : S_PRESS;
                else             next_d = evacd_q  ? S_OUTER : S_EVAC;
                advance_d = (bus.arrive_req || bus.depart_req) && !bus.pause;
            end
            S_EVAC: begin
                next_d    = S_OUTER;
                advance_d = cnt_zero_d && !bus.pause;
            end
            S_PRESS: begin
                next_d    = S_INNER;
                advance_d = cnt_zero_d && !bus.pause;
            end
            S_OUTER: begin
                next_d    = dir_q ? S_DONE : S_PRESS;
                advance_d = cnt_zero_d && !bus.pause;
            end
            S_INNER: begin
                next_d    = dir_q ? S_EVAC : S_DONE;
                advance_d = cnt_zero_d && !bus.pause;
            end
            S_DONE: begin
                next_d    = S_IDLE;
                advance_d = !bus.pause;
            end
            default: begin
                next_d    = S_IDLE;
                advance_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            last_dir_q <= 1'b1;
            evac_q     <= 1'b0;
            press_q    <= 1'b0;
            outer_q    <= 1'b0;
            inner_q    <= 1'b0;
            pressd_q   <= 1'b1;
            evacd_q    <= 1'b0;
            agrant_q   <= 1'b0;
            dgrant_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            agrant_q <= 1'b0;
            dgrant_q <= 1'b0;
            done_q   <= 1'b0;
            if (advance_d) begin
                state_q <= next_d;
                busy_q  <= (next_d != S_IDLE);
                evac_q  <= (next_d == S_EVAC);
                press_q <= (next_d == S_PRESS);
                outer_q <= (next_d == S_OUTER);
                inner_q <= (next_d == S_INNER);
                done_q  <= (next_d == S_DONE);
                case (next_d)
                    S_EVAC:           cnt_q <= EVAC_LD;
                    S_PRESS:          cnt_q <= PRESS_LD;
                    S_OUTER, S_INNER: cnt_q <= DOOR_LD;
                    default:          cnt_q <= '0;
                endcase
                if (state_q == S_IDLE) begin
                    dir_q      <= start_dir_d;
                    last_dir_q <= start_dir_d;
                    agrant_q   <= ~start_dir_d;
                    dgrant_q   <= start_dir_d;
                end
                if (state_q == S_EVAC)  evacd_q  <= 1'b1;
                if (state_q == S_PRESS) pressd_q <= 1'b1;
                if (next_d == S_EVAC)   pressd_q <= 1'b0;
                if (next_d == S_PRESS)  evacd_q  <= 1'b0;
            end else if (!bus.pause && !cnt_zero_d) begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

    assign bus.arrive_grant = agrant_q;
    assign bus.depart_grant = dgrant_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.evacuate     = evac_q;
    assign bus.pressurize   = press_q;
    assign bus.outer_door   = outer_q;
    assign bus.inner_door   = inner_q;
    assign bus.pressurized  = pressd_q;
    assign bus.evacuated    = evacd_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_airlock_sequencer.sv
// Directed bench for airlock_sequencer: per-cycle expected outputs are queued
// as each scenario is driven and compared on the falling edge.
module tb_airlock_sequencer;
    localparam logic [2:0] IDLE = 3'd0, EVAC = 3'd1, PRESS = 3'd2,
                           OUTER = 3'd3, INNER = 3'd4, DONE = 3'd5;

    typedef struct packed {
        logic [2:0] st;
        logic ag, dg, dn, bz, ev, pr, od, id, pzd, evd;
    } exp_t;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    airlock_sequencer_if bus ();

    airlock_sequencer #(
        .EVAC_CYCLES (8),
        .PRESS_CYCLES(8),
        .DOOR_CYCLES (4),
        .CNT_W       (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Push n cycles of expected outputs for one phase; pulses only on cycle 0.
    task automatic seg(input logic [2:0] st, input int n, input logic pzd,
                       input logic evd, input logic ag, input logic dg);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.st  = st;
            e.ag  = ag && (i == 0);
            e.dg  = dg && (i == 0);
            e.dn  = (st == DONE) && (i == 0);
            e.bz  = (st != IDLE);
            e.ev  = (st == EVAC);
            e.pr  = (st == PRESS);
            e.od  = (st == OUTER);
            e.id  = (st == INNER);
            e.pzd = pzd;
            e.evd = evd;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL drain: %0d expectations left, required 0", sb.size());
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_t obs;
        exp_t e;
        obs = {bus.dbg_state, bus.arrive_grant, bus.depart_grant, bus.done,
               bus.busy, bus.evacuate, bus.pressurize, bus.outer_door,
               bus.inner_door, bus.pressurized, bus.evacuated};
        if (sb.size() != 0) begin
            e = sb.pop_front();
            total++;
            assert (obs === e) else begin
                bad++;
                $error("FAIL cycle t=%0t observed=%b required=%b", $time, obs, e);
            end
        end
        total++;
        assert ($countones({bus.evacuate, bus.pressurize, bus.outer_door, bus.inner_door}) <= 1)
        else begin
            bad++;
            $error("FAIL one_actuator t=%0t observed=%b required=at most one", $time,
                   {bus.evacuate, bus.pressurize, bus.outer_door, bus.inner_door});
        end
        total++;
        assert ((!bus.inner_door || bus.pressurized) && (!bus.outer_door || bus.evacuated)
                && !(bus.arrive_grant && bus.depart_grant)
                && !(bus.pressurized && bus.evacuated)) else begin
            bad++;
            $error("FAIL interlock t=%0t observed id/pz/od/ev/ag/dg=%b required=consistent",
                   $time, {bus.inner_door, bus.pressurized, bus.outer_door, bus.evacuated,
                           bus.arrive_grant, bus.depart_grant});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus.arrive_req = 1'b0;
        bus.depart_req = 1'b0;
        bus.pause      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        seg(IDLE, 1, 1, 0, 0, 0);
        reset = 1'b0;
        drain(10);

        // Arrival from reset: full EVAC/OUTER/PRESS/INNER transit
        bus.arrive_req = 1'b1;
        seg(IDLE, 1, 1, 0, 0, 0);
        seg(EVAC, 8, 0, 0, 1, 0);
        seg(OUTER, 4, 0, 1, 0, 0);
        seg(PRESS, 8, 0, 0, 0, 0);
        seg(INNER, 4, 1, 0, 0, 0);
        seg(DONE, 1, 1, 0, 0, 0);
        seg(IDLE, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        bus.arrive_req = 1'b0;
        drain(60);

        // Departure while pressurized: skips PRESS
        bus.depart_req = 1'b1;
        seg(IDLE, 1, 1, 0, 0, 0);
        seg(INNER, 4, 1, 0, 0, 1);
        seg(EVAC, 8, 0, 0, 0, 0);
        seg(OUTER, 4, 0, 1, 0, 0);
        seg(DONE, 1, 0, 1, 0, 0);
        seg(IDLE, 1, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        bus.depart_req = 1'b0;
        drain(60);

        // Arrival with chamber evacuated: skips EVAC
        bus.arrive_req = 1'b1;
        seg(IDLE, 1, 0, 1, 0, 0);
        seg(OUTER, 4, 0, 1, 1, 0);
        seg(PRESS, 8, 0, 0, 0, 0);
        seg(INNER, 4, 1, 0, 0, 0);
        seg(DONE, 1, 1, 0, 0, 0);
        seg(IDLE, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        bus.arrive_req = 1'b0;
        drain(60);

        // Pause for 5 cycles starting at the third PRESS cycle
        bus.arrive_req = 1'b1;
        seg(IDLE, 1, 1, 0, 0, 0);
        seg(EVAC, 8, 0, 0, 1, 0);
        seg(OUTER, 4, 0, 1, 0, 0);
        seg(PRESS, 13, 0, 0, 0, 0);
        seg(INNER, 4, 1, 0, 0, 0);
        seg(DONE, 1, 1, 0, 0, 0);
        seg(IDLE, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        bus.arrive_req = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        bus.pause = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.pause = 1'b0;
        drain(60);

        // Pause in IDLE with a pending request: grant only after pause falls
        bus.pause      = 1'b1;
        bus.arrive_req = 1'b1;
        seg(IDLE, 5, 1, 0, 0, 0);
        seg(EVAC, 8, 0, 0, 1, 0);
        seg(OUTER, 4, 0, 1, 0, 0);
        seg(PRESS, 8, 0, 0, 0, 0);
        seg(INNER, 4, 1, 0, 0, 0);
        seg(DONE, 1, 1, 0, 0, 0);
        seg(IDLE, 1, 1, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        bus.pause = 1'b0;
        @(posedge clk);
        #1;
        bus.arrive_req = 1'b0;
        drain(60);

        // Both requests held from reset: arrive, depart, arrive, depart
        reset          = 1'b1;
        bus.arrive_req = 1'b1;
        bus.depart_req = 1'b1;
        seg(IDLE, 1, 1, 0, 0, 0);
        seg(IDLE, 1, 1, 0, 0, 0);
        seg(EVAC, 8, 0, 0, 1, 0);
        seg(OUTER, 4, 0, 1, 0, 0);
        seg(PRESS, 8, 0, 0, 0, 0);
        seg(INNER, 4, 1, 0, 0, 0);
        seg(DONE, 1, 1, 0, 0, 0);
        seg(IDLE, 1, 1, 0, 0, 0);
        seg(INNER, 4, 1, 0, 0, 1);
        seg(EVAC, 8, 0, 0, 0, 0);
        seg(OUTER, 4, 0, 1, 0, 0);
        seg(DONE, 1, 0, 1, 0, 0);
        seg(IDLE, 1, 0, 1, 0, 0);
        seg(OUTER, 4, 0, 1, 1, 0);
        seg(PRESS, 8, 0, 0, 0, 0);
        seg(INNER, 4, 1, 0, 0, 0);
        seg(DONE, 1, 1, 0, 0, 0);
        seg(IDLE, 1, 1, 0, 0, 0);
        seg(INNER, 4, 1, 0, 0, 1);
        seg(EVAC, 8, 0, 0, 0, 0);
        seg(OUTER, 4, 0, 1, 0, 0);
        seg(DONE, 1, 0, 1, 0, 0);
        seg(IDLE, 2, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (63) @(posedge clk);
        #1;
        bus.arrive_req = 1'b0;
        bus.depart_req = 1'b0;
        drain(60);

        // Reset during OUTER of an arrival: no done pulse, chamber flags restored
        bus.arrive_req = 1'b1;
        seg(IDLE, 1, 0, 1, 0, 0);
        seg(OUTER, 2, 0, 1, 1, 0);
        seg(IDLE, 3, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        bus.arrive_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
